fir_out_requant: RTL and testbench

// - Sink for the transposed FIR output stream: takes one full-precision sample
//   per in_valid cycle, scales it (arithmetic right shift), saturates it to OUT_W

---
 rtl/fir_out_requant.sv | 142 ++++++++++++++
 tb/tb_fir_out_requant.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant.sv
// Requantizes FIR output (arith shift, optional round via FIR_REQ_ROUND_EN, saturate) into a show-ahead FIFO.
// Latency: in_valid at cycle N -> out_valid at N+2 when the FIFO was empty.
// Backpressure: none toward the FIR; samples arriving while full are dropped and counted.
module fifo_sync #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic          push_ok,
  output logic          pop_ok,
  output logic          full,
  output logic          not_empty,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Occupancy counter is the single source of truth for full/empty.
  assign not_empty = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop_ok    = pop & not_empty;
  assign push_ok   = push & (~full | pop_ok);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module fir_out_requant #(
  parameter int BIT_PREC   = 8,
  parameter int TAPS       = 5,
  parameter int IN_W       = 2*BIT_PREC+TAPS-1,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_sample,
  input  logic                          clr_flags,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic                          sat_flag,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EW-1:0] ext, adj, shd;
  logic                 sat_hi, sat_lo, sat_ev;
  logic [OUT_W-1:0]     sat_val;
  logic                 s1_valid;
  logic [OUT_W-1:0]     s1_data;
  logic                 push_ok, pop_ok, fifo_full, drop;

  assign ext = {in_sample[IN_W-1], in_sample};
`ifdef FIR_REQ_ROUND_EN
  localparam logic signed [EW-1:0] RND = EW'(2**(SHIFT-1));
  // One guard bit of headroom keeps the rounding add from wrapping.
  assign adj = ext + RND;
`else
  assign adj = ext;
`endif
  assign shd     = adj >>> SHIFT;
  assign sat_hi  = (shd > MAXV);
  assign sat_lo  = (shd < MINV);
  assign sat_ev  = in_valid & (sat_hi | sat_lo);
  assign sat_val = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                   sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : shd[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      sat_flag <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= sat_val;
      if (sat_ev)         sat_flag <= 1'b1;
      else if (clr_flags) sat_flag <= 1'b0;
    end
  end

  fifo_sync #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_valid),
    .push_dat  (s1_data),
    .pop       (out_ready),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .full      (fifo_full),
    .not_empty (out_valid),
    .head      (out_data),
    .level     (fifo_level)
  );

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign drop = s1_valid & ~push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (drop) begin
      if (clr_flags)              drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_flags) begin
      drop_cnt <= 8'd0;
    end
  end

  logic unused_ok;
  assign unused_ok = pop_ok & fifo_full;
endmodule

// File: tb/tb_fir_out_requant.sv
// Table vectors, hand-written corner sequences and random traffic checked against a queue-based model.
module tb_fir_out_requant;
  localparam int IN_W  = 20;
  localparam int OUT_W = 16;
  localparam int SHIFT = 2;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
`ifdef FIR_REQ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, clr_flags = 1'b0, out_ready = 1'b0;
  logic [IN_W-1:0]  in_sample = '0;
  logic             out_valid, sat_flag;
  logic [OUT_W-1:0] out_data;
  logic [7:0]       drop_cnt;
  logic [LW-1:0]    fifo_level;

  fir_out_requant dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample),
    .clr_flags(clr_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference state: a queue of accepted samples plus the one-cycle stage-1 slot.
  int q[$];
  bit m_s1v;
  int m_s1d;
  bit m_sat;
  int m_drop;

  function automatic int ref_q(input int x, output bit sat);
    int v, d, r;
    d = 1 << SHIFT;
    v = x + (RND ? d/2 : 0);
    r = v / d;
    if ((v % d) != 0 && v < 0) r = r - 1;
    sat = 1'b0;
    if (r > 32767)       begin r = 32767;  sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [OUT_W-1:0] d);
    return 32'($signed(d));
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1v = 1'b0; m_s1d = 0; m_sat = 1'b0; m_drop = 0;
  endtask

  task automatic step();
    bit sat_ev, drop_ev;
    int v;
    @(posedge clk);
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    drop_ev = 1'b0;
    if (m_s1v) begin
      if (q.size() < DEPTH) q.push_back(m_s1d);
      else drop_ev = 1'b1;
    end
    v = ref_q(int'($signed(in_sample)), sat_ev);
    sat_ev = sat_ev & in_valid;
    m_sat  = sat_ev ? 1'b1 : (clr_flags ? 1'b0 : m_sat);
    if (drop_ev) m_drop = clr_flags ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    else if (clr_flags) m_drop = 0;
    m_s1v = in_valid;
    if (in_valid) m_s1d = v;
    #1;
    chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_level", 32'(fifo_level), 32'(q.size()));
    if (q.size() > 0) chk("m_data", sx(out_data), 32'(q[0]));
    chk("m_sat", 32'(sat_flag), 32'(m_sat));
    chk("m_drop", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_sat"},   32'(sat_flag), 0);
    chk({tag, "_drop"},  32'(drop_cnt), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; in_valid = 1'b0; clr_flags = 1'b0; out_ready = 1'b0; in_sample = '0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int smp;
    int exp_t;
    int exp_r;
    bit sat_t;
    bit sat_r;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{400,      100,    100,    1'b0, 1'b0};
    vecs[1]  = '{-6,       -2,     -1,     1'b0, 1'b0};
    vecs[2]  = '{6,        1,      2,      1'b0, 1'b0};
    vecs[3]  = '{200000,   32767,  32767,  1'b1, 1'b1};
    vecs[4]  = '{-200000,  -32768, -32768, 1'b1, 1'b1};
    vecs[5]  = '{0,        0,      0,      1'b0, 1'b0};
    vecs[6]  = '{3,        0,      1,      1'b0, 1'b0};
    vecs[7]  = '{-1,       -1,     0,      1'b0, 1'b0};
    vecs[8]  = '{131071,   32767,  32767,  1'b0, 1'b1};
    vecs[9]  = '{-131072,  -32768, -32768, 1'b0, 1'b0};
    vecs[10] = '{-131073,  -32768, -32768, 1'b1, 1'b0};
    vecs[11] = '{524287,   32767,  32767,  1'b1, 1'b1};
    vecs[12] = '{-524288,  -32768, -32768, 1'b1, 1'b1};

    do_reset("rst");
    for (int i = 0; i < 10; i++) begin
      step();
      check_zero("idle");
    end

    // Single-sample vectors: latency, value and saturation flag.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("clr_sat", 32'(sat_flag), 0);
      in_valid = 1'b1; in_sample = IN_W'(vecs[i].smp);
      step();
      in_valid = 1'b0;
      chk("lat1_valid", 32'(out_valid), 0);
      step();
      chk("lat2_valid", 32'(out_valid), 1);
      chk("vec_data", sx(out_data), 32'(RND ? vecs[i].exp_r : vecs[i].exp_t));
      chk("vec_sat", 32'(sat_flag), 32'(RND ? vecs[i].sat_r : vecs[i].sat_t));
      step();
    end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_final", 32'(sat_flag), 0);

    // Overflow: six samples into a stalled four-entry FIFO.
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_sample = IN_W'(4*i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_drop", 32'(drop_cnt), 2);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", sx(out_data), 32'(i));
      step();
    end
    chk("ovf_empty", 32'(fifo_level), 0);

    // Full with simultaneous push and pop: level holds, nothing dropped.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_sample = IN_W'(40*i);
      step();
    end
    out_ready = 1'b1; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_sample = IN_W'(8*i);
      step();
      chk("full_level", 32'(fifo_level), 4);
      chk("full_drop", 32'(drop_cnt), 0);
    end
    #3;
    do_reset("midrst");

    // Drop counter saturation, then clear racing a new drop.
    out_ready = 1'b0; in_valid = 1'b1; in_sample = IN_W'(100);
    for (int i = 0; i < 265; i++) step();
    chk("drop_sat", 32'(drop_cnt), 255);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("drop_clr_race", 32'(drop_cnt), 1);
    in_sample = IN_W'(200000); clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("sat_clr_race", 32'(sat_flag), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 1) == 1);
      clr_flags = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 2))
        0:       in_sample = IN_W'($urandom);
        1:       in_sample = IN_W'(int'($urandom_range(0, 400)) - 200);
        default: in_sample = IN_W'(int'($urandom_range(0, 8000)) + 127000);
      endcase
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
